// File: rtl/l2_port_arbiter.sv
// l2_port_arbiter: shares one L2 request port between Icache refills,
// Dcache refills and Dcache dirty-line writebacks. Each L1 pulse is parked
// in a pending slot and the slots are issued one at a time over a
// valid/ready channel. Writebacks go first so an evict always reaches L2
// before the refill that replaces it. Reads alternate round-robin.
module l2_port_arbiter #(
  parameter int address_width = 32,
  parameter int data_width    = 32,
  parameter int block_size    = 32,
  localparam int line_addr_w  = address_width - $clog2(data_width * block_size / 8),
  localparam int cache_width  = block_size * data_width
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   IC_ADDR_VALID,
  input  logic [line_addr_w-1:0] IC_ADDR,
  output logic [cache_width-1:0] IC_DATA,
  output logic                   IC_DATA_VALID,
  input  logic                   DC_ADDR_VALID,
  input  logic [line_addr_w-1:0] DC_ADDR,
  output logic [cache_width-1:0] DC_DATA,
  output logic                   DC_DATA_VALID,
  input  logic                   DC_WB_VALID,
  input  logic [line_addr_w-1:0] DC_WB_ADDR,
  input  logic [cache_width-1:0] DC_WB_DATA,
  output logic                   DC_WB_DONE,
  output logic                   L2_REQ_VALID,
  input  logic                   L2_REQ_READY,
  output logic                   L2_REQ_WRITE,
  output logic [line_addr_w-1:0] L2_REQ_ADDR,
  output logic [cache_width-1:0] L2_WDATA,
  input  logic [cache_width-1:0] L2_RDATA,
  input  logic                   L2_RDATA_VALID,
  input  logic                   L2_WACK,
  output logic                   PROTO_ERR
);

  // Source slot indices; also the encoding of the current grant.
  localparam logic [1:0] SRC_IC = 2'd0;
  localparam logic [1:0] SRC_DC = 2'd1;
  localparam logic [1:0] SRC_WB = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    WAIT_W = 2'd3
  } state_t;

  state_t                 state_reg, state_next;
  logic [1:0]             grant_reg, grant_next;
  logic                   rr_dc_reg, rr_dc_next;  // 1: DC wins a read tie
  logic                   issue;
  logic                   rd_done, wr_done;

  logic [2:0]             pulse;
  logic [2:0]             pend;
  logic [2:0]             clear;
  logic [2:0]             accept;
  logic [2:0]             collide;
  logic [line_addr_w-1:0] pulse_addr [3];
  logic [line_addr_w-1:0] pend_addr  [3];
  logic [line_addr_w-1:0] grant_addr;
  logic [cache_width-1:0] wb_data_reg;

  logic                   req_valid_reg;
  logic                   req_write_reg;
  logic [line_addr_w-1:0] req_addr_reg;
  logic [cache_width-1:0] wdata_reg;
  logic [cache_width-1:0] ic_data_reg;
  logic                   ic_valid_reg;
  logic [cache_width-1:0] dc_data_reg;
  logic                   dc_valid_reg;
  logic                   wb_done_reg;
  logic                   proto_err_reg;

  assign pulse         = {DC_WB_VALID, DC_ADDR_VALID, IC_ADDR_VALID};
  assign pulse_addr[0] = IC_ADDR;
  assign pulse_addr[1] = DC_ADDR;
  assign pulse_addr[2] = DC_WB_ADDR;

  // Completion of the outstanding transaction frees its source slot.
  assign rd_done  = (state_reg == WAIT_R) && L2_RDATA_VALID;
  assign wr_done  = (state_reg == WAIT_W) && L2_WACK;
  assign clear[0] = rd_done && (grant_reg == SRC_IC);
  assign clear[1] = rd_done && (grant_reg == SRC_DC);
  assign clear[2] = wr_done;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_src
      logic                   pend_reg;
      logic [line_addr_w-1:0] addr_reg;

      // A slot being freed this cycle may be refilled by a pulse in the same cycle.
      assign accept[gi]    = pulse[gi] && (!pend_reg || clear[gi]);
      assign collide[gi]   = pulse[gi] && pend_reg && !clear[gi];
      assign pend[gi]      = pend_reg;
      assign pend_addr[gi] = addr_reg;

      // Pending flag and line address for this source; first request wins.
      always_ff @(posedge CLK) begin
        if (RST) begin
          pend_reg <= 1'b0;
          addr_reg <= '0;
        end else if (accept[gi]) begin
          pend_reg <= 1'b1;
          addr_reg <= pulse_addr[gi];
        end else if (clear[gi]) begin
          pend_reg <= 1'b0;
        end
      end
    end
  endgenerate

  // Writeback line data is parked alongside the writeback address.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wb_data_reg <= '0;
    end else if (accept[2]) begin
      wb_data_reg <= DC_WB_DATA;
    end
  end

  // FSM state, grant and round-robin pointer registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= IDLE;
      grant_reg <= SRC_IC;
      rr_dc_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      rr_dc_reg <= rr_dc_next;
    end
  end

  // Next-state logic: pick a source in IDLE, then follow the L2 handshake.
  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    rr_dc_next = rr_dc_reg;
    issue      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pend != 3'b000) begin
          issue      = 1'b1;
          state_next = REQ;
          if (pend[2]) begin
            grant_next = SRC_WB;
          end else if (pend[0] && pend[1]) begin
            grant_next = rr_dc_reg ? SRC_DC : SRC_IC;
          end else if (pend[0]) begin
            grant_next = SRC_IC;
          end else begin
            grant_next = SRC_DC;
          end
          if (grant_next == SRC_IC) begin
            rr_dc_next = 1'b1;
          end else if (grant_next == SRC_DC) begin
            rr_dc_next = 1'b0;
          end
        end
      end
      REQ: begin
        if (L2_REQ_READY) begin
          state_next = (grant_reg == SRC_WB) ? WAIT_W : WAIT_R;
        end
      end
      WAIT_R: begin
        if (L2_RDATA_VALID) begin
          state_next = IDLE;
        end
      end
      WAIT_W: begin
        if (L2_WACK) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Address of the source being granted this cycle.
  always_comb begin
    case (grant_next)
      SRC_IC:  grant_addr = pend_addr[0];
      SRC_DC:  grant_addr = pend_addr[1];
      default: grant_addr = pend_addr[2];
    endcase
  end

  // Registered L2 request channel and L1 return paths.
  always_ff @(posedge CLK) begin
    if (RST) begin
      req_valid_reg <= 1'b0;
      req_write_reg <= 1'b0;
      req_addr_reg  <= '0;
      wdata_reg     <= '0;
      ic_data_reg   <= '0;
      ic_valid_reg  <= 1'b0;
      dc_data_reg   <= '0;
      dc_valid_reg  <= 1'b0;
      wb_done_reg   <= 1'b0;
      proto_err_reg <= 1'b0;
    end else begin
      ic_valid_reg <= 1'b0;
      dc_valid_reg <= 1'b0;
      wb_done_reg  <= 1'b0;
      if (issue) begin
        req_valid_reg <= 1'b1;
        req_write_reg <= (grant_next == SRC_WB);
        req_addr_reg  <= grant_addr;
        if (grant_next == SRC_WB) begin
          wdata_reg <= wb_data_reg;
        end
      end else if ((state_reg == REQ) && L2_REQ_READY) begin
        req_valid_reg <= 1'b0;
      end
      if (rd_done) begin
        if (grant_reg == SRC_IC) begin
          ic_data_reg  <= L2_RDATA;
          ic_valid_reg <= 1'b1;
        end else begin
          dc_data_reg  <= L2_RDATA;
          dc_valid_reg <= 1'b1;
        end
      end
      if (wr_done) begin
        wb_done_reg <= 1'b1;
      end
      if (collide != 3'b000) begin
        proto_err_reg <= 1'b1;
      end
    end
  end

  assign L2_REQ_VALID  = req_valid_reg;
  assign L2_REQ_WRITE  = req_write_reg;
  assign L2_REQ_ADDR   = req_addr_reg;
  assign L2_WDATA      = wdata_reg;
  assign IC_DATA       = ic_data_reg;
  assign IC_DATA_VALID = ic_valid_reg;
  assign DC_DATA       = dc_data_reg;
  assign DC_DATA_VALID = dc_valid_reg;
  assign DC_WB_DONE    = wb_done_reg;
  assign PROTO_ERR     = proto_err_reg;

endmodule
